// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - framed byte-stream loader that fills instruction memory and releases the core
module imem_boot_loader #(
   parameter int unsigned DEPTH_LOG2     = 8,
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        in_valid_i,
   input  logic [7:0]  in_data_i,
   output logic        in_ready_o,
   output logic        imem_we_o,
   output logic [31:0] imem_addr_o,
   output logic [31:0] imem_wdata_o,
   output logic        cpu_reset_o,
   output logic        boot_done_o,
   output logic        boot_error_o,
   output logic [1:0]  err_code_o,
   output logic [15:0] words_loaded_o
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [16:0] MAX_WORDS = 17'd1 << DEPTH_LOG2;

   typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

   state_t        state_q, state_d;
   logic [15:0]   len_q, len_d;
   logic [31:0]   asm_q, asm_d;
   logic [1:0]    bidx_q, bidx_d;
   logic [7:0]    csum_q, csum_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [1:0]    err_q, err_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [15:0]   wl_q, wl_d;
   logic          ready_q, cpu_reset_q, done_q, error_q;
   logic          accept, timed;
   logic [15:0]   n;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      asm_d   = asm_q;
      bidx_d  = bidx_q;
      csum_d  = csum_q;
      tmo_d   = tmo_q;
      err_d   = err_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wl_d    = wl_q;
      accept  = in_valid_i && ready_q;
      timed   = state_q inside {S_LEN1, S_DATA, S_CSUM};
      n       = {in_data_i, len_q[7:0]};

      if (timed) tmo_d = accept ? '0 : tmo_q + TW'(1);
      if (accept && (state_q inside {S_LEN0, S_LEN1, S_DATA})) csum_d = csum_q + in_data_i;

      case (state_q)
         S_LEN0: if (accept) begin
            len_d[7:0] = in_data_i;
            state_d    = S_LEN1;
         end
         S_LEN1: if (accept) begin
            len_d[15:8] = in_data_i;
            if (n == 16'd0 || {1'b0, n} > MAX_WORDS) begin
               state_d = S_ERR;
               err_d   = 2'b01;
            end else begin
               state_d = S_DATA;
            end
         end
         S_DATA: if (accept) begin
            // Bytes arrive LSB first, so shifting in from the top leaves the word little-endian.
            asm_d  = {in_data_i, asm_q[31:8]};
            bidx_d = bidx_q + 2'd1;
            if (bidx_q == 2'd3) begin
               we_d    = 1'b1;
               wdata_d = asm_d;
               addr_d  = BASE_ADDR + {14'd0, wl_q, 2'b00};
               wl_d    = wl_q + 16'd1;
               if (wl_q == len_q - 16'd1) state_d = S_CSUM;
            end
         end
         S_CSUM: if (accept) begin
            if (in_data_i == csum_q) begin
               state_d = S_DONE;
            end else begin
               state_d = S_ERR;
               err_d   = 2'b10;
            end
         end
         default: ;
      endcase

      // An idle cycle never coincides with a state change above, so this override is safe.
      if (timed && !accept && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
         state_d = S_ERR;
         err_d   = 2'b11;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= S_LEN0;
         len_q       <= '0;
         asm_q       <= '0;
         bidx_q      <= '0;
         csum_q      <= '0;
         tmo_q       <= '0;
         err_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= BASE_ADDR;
         wdata_q     <= '0;
         wl_q        <= '0;
         ready_q     <= 1'b1;
         cpu_reset_q <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         asm_q       <= asm_d;
         bidx_q      <= bidx_d;
         csum_q      <= csum_d;
         tmo_q       <= tmo_d;
         err_q       <= err_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wl_q        <= wl_d;
         ready_q     <= (state_d != S_DONE);
         cpu_reset_q <= (state_d != S_DONE);
         done_q      <= (state_d == S_DONE);
         error_q     <= (state_d == S_ERR);
      end
   end

   assign in_ready_o     = ready_q;
   assign imem_we_o      = we_q;
   assign imem_addr_o    = addr_q;
   assign imem_wdata_o   = wdata_q;
   assign cpu_reset_o    = cpu_reset_q;
   assign boot_done_o    = done_q;
   assign boot_error_o   = error_q;
   assign err_code_o     = err_q;
   assign words_loaded_o = wl_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - table, hand-sequence and randomized checks of imem_boot_loader
module tb_imem_boot_loader;
   localparam int DL = 8;
   localparam int TO = 16;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic [95:0] b;
      int          nb;
      logic        done;
      logic [1:0]  code;
      int          words;
      int          maxgap;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, imem_we, cpu_reset, boot_done, boot_error;
   logic [7:0]  in_data;
   logic [31:0] imem_addr, imem_wdata;
   logic [1:0]  err_code;
   logic [15:0] words_loaded;

   imem_boot_loader #(.DEPTH_LOG2(DL), .BASE_ADDR(32'h0), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_data_i(in_data),
      .in_ready_o(in_ready), .imem_we_o(imem_we), .imem_addr_o(imem_addr),
      .imem_wdata_o(imem_wdata), .cpu_reset_o(cpu_reset), .boot_done_o(boot_done),
      .boot_error_o(boot_error), .err_code_o(err_code), .words_loaded_o(words_loaded));

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0;
   logic [31:0] wq_a[$], wq_d[$], exp_a[$], exp_d[$];
   logic        m_done, m_err;
   logic [1:0]  m_code;

   always @(negedge clk) if (imem_we === 1'b1) begin
      wq_a.push_back(imem_addr);
      wq_d.push_back(imem_wdata);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      wq_a.delete(); wq_d.delete();
   endtask

   task automatic put_byte(input logic [7:0] b, input int gap);
      int t;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1; in_data = b;
      t = 0;
      while (in_ready !== 1'b1 && t < 40) begin @(negedge clk); t++; end
      if (t >= 40) chk("ready_wait", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send(input bq_t fr, input int maxgap);
      foreach (fr[i]) put_byte(fr[i], ($urandom_range(0, 2) == 0) ? $urandom_range(0, maxgap) : 0);
   endtask

   // Frame semantics: length check, word extraction, mod-256 sum of everything before CSUM.
   task automatic model(input bq_t fr);
      int n;
      logic [7:0] s;
      exp_a.delete(); exp_d.delete();
      m_done = 1'b0; m_err = 1'b0; m_code = 2'b00;
      n = int'({fr[1], fr[0]});
      if (n == 0 || n > (1 << DL)) begin m_err = 1'b1; m_code = 2'b01; return; end
      for (int k = 0; k < n; k++)
         if (2 + 4*k + 3 < fr.size()) begin
            exp_a.push_back(32'(4*k));
            exp_d.push_back({fr[2+4*k+3], fr[2+4*k+2], fr[2+4*k+1], fr[2+4*k]});
         end
      s = 8'h00;
      for (int i = 0; i < 2 + 4*n; i++) s = s + fr[i];
      if (fr.size() > 2 + 4*n) begin
         if (fr[2+4*n] == s) m_done = 1'b1;
         else begin m_err = 1'b1; m_code = 2'b10; end
      end
   endtask

   task automatic check_outcome(input string tag, input logic done, input logic [1:0] code, input int words);
      repeat (2) @(negedge clk);
      #1;
      chk({tag, "_nwrites"}, wq_a.size(), exp_a.size());
      for (int k = 0; k < wq_a.size() && k < exp_a.size(); k++) begin
         chk({tag, "_addr"}, wq_a[k], exp_a[k]);
         chk({tag, "_wdata"}, wq_d[k], exp_d[k]);
      end
      chk({tag, "_done"}, {31'd0, boot_done}, {31'd0, done});
      chk({tag, "_error"}, {31'd0, boot_error}, {31'd0, !done});
      chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, !done});
      chk({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, !done});
      chk({tag, "_err_code"}, {30'd0, err_code}, {30'd0, code});
      chk({tag, "_words"}, {16'd0, words_loaded}, 32'(words));
   endtask

   vec_t tbl[6];
   bq_t  fr;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{{56'h01_00_13_00_00_00_14, 40'h0}, 7, 1'b1, 2'b00, 1, 0};
      tbl[1] = '{{88'h02_00_93_00_50_00_B3_01_00_00_99, 8'h0}, 11, 1'b1, 2'b00, 2, 8};
      tbl[2] = '{{88'h02_00_93_00_50_00_B3_01_00_00_87, 8'h0}, 11, 1'b0, 2'b10, 2, 8};
      tbl[3] = '{{56'h01_00_13_00_00_00_15, 40'h0}, 7, 1'b0, 2'b10, 1, 0};
      tbl[4] = '{{16'h00_00, 80'h0}, 2, 1'b0, 2'b01, 0, 0};
      tbl[5] = '{{16'h01_01, 80'h0}, 2, 1'b0, 2'b01, 0, 0};

      do_reset();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      chk("rst_we", {31'd0, imem_we}, 32'd0);
      chk("rst_done_err", {30'd0, boot_done, boot_error}, 32'd0);
      chk("rst_err_code", {30'd0, err_code}, 32'd0);
      chk("rst_words", {16'd0, words_loaded}, 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_wdata", imem_wdata, 32'h0);

      foreach (tbl[i]) begin
         do_reset();
         fr.delete();
         for (int j = 0; j < tbl[i].nb; j++) fr.push_back(tbl[i].b[95-8*j -: 8]);
         model(fr);
         send(fr, tbl[i].maxgap);
         check_outcome($sformatf("vec%0d", i), tbl[i].done, tbl[i].code, tbl[i].words);
         if (i == 3) begin
            put_byte(8'hAA, 0);
            put_byte(8'h55, 0);
            check_outcome("drain", 1'b0, 2'b10, 1);
         end
      end

      // Single word: strobe latency and done latency.
      do_reset();
      put_byte(8'h01, 0); put_byte(8'h00, 0); put_byte(8'h13, 0);
      put_byte(8'h00, 0); put_byte(8'h00, 0);
      chk("lat_we_early", {31'd0, imem_we}, 32'd0);
      put_byte(8'h00, 0);
      chk("lat_we", {31'd0, imem_we}, 32'd1);
      chk("lat_addr", imem_addr, 32'h0);
      chk("lat_wdata", imem_wdata, 32'h13);
      chk("lat_words", {16'd0, words_loaded}, 32'd1);
      chk("lat_done_early", {31'd0, boot_done}, 32'd0);
      put_byte(8'h14, 0);
      chk("lat_we_single", {31'd0, imem_we}, 32'd0);
      chk("lat_done", {31'd0, boot_done}, 32'd1);
      chk("lat_cpu_reset", {31'd0, cpu_reset}, 32'd0);

      // Timeout: none while waiting for LEN_LO, then exactly TO idle cycles mid-frame.
      do_reset();
      repeat (3*TO) @(negedge clk);
      chk("len0_no_timeout", {31'd0, boot_error}, 32'd0);
      put_byte(8'h01, 0); put_byte(8'h00, 0); put_byte(8'h13, 0); put_byte(8'h00, 0);
      for (int i = 1; i <= TO; i++) begin
         @(negedge clk);
         chk($sformatf("timeout_c%0d", i), {31'd0, boot_error}, {31'd0, (i == TO)});
      end
      repeat (4) @(negedge clk);
      #1;
      chk("timeout_code", {30'd0, err_code}, 32'd3);
      chk("timeout_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      chk("timeout_nwrites", wq_a.size(), 32'd0);

      // Reset mid-DATA, then a clean frame.
      do_reset();
      put_byte(8'h01, 0); put_byte(8'h00, 0); put_byte(8'hAA, 0); put_byte(8'hBB, 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort_nwrites", wq_a.size(), 32'd0);
      chk("abort_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      chk("abort_words", {16'd0, words_loaded}, 32'd0);
      fr = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h14};
      model(fr);
      send(fr, 0);
      check_outcome("after_abort", 1'b1, 2'b00, 1);

      // Randomized frames, including the maximum length at full rate.
      for (int it = 0; it < 8; it++) begin
         int n;
         logic [7:0] s;
         logic bad;
         n   = (it == 0) ? (1 << DL) : $urandom_range(1, 6);
         bad = (it != 0) && ($urandom_range(0, 2) == 0);
         fr.delete();
         fr.push_back(n[7:0]);
         fr.push_back(n[15:8]);
         for (int j = 0; j < 4*n; j++) fr.push_back(8'($urandom));
         s = 8'h00;
         foreach (fr[j]) s = s + fr[j];
         fr.push_back(bad ? (s ^ 8'h5A) : s);
         model(fr);
         do_reset();
         send(fr, (it == 0) ? 0 : TO - 2);
         check_outcome($sformatf("rand%0d", it), m_done, m_code, n);
         if (it == 0) chk("max_last_addr", wq_a.size() > 0 ? wq_a[wq_a.size()-1] : 32'hFFFF_FFFF, 32'h3FC);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
